slope_sequencer: RTL and testbench
==================================

SLOPE_SEQUENCER -- requirements
Module: slope_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, width of sampled waveform datain.
REQ-002 SHALL have parameter PW, default 16, width of period and timeout counters.
REQ-003 SHALL have parameter NCYC, default 4, number of periods measured per run (1..255).
REQ-004 SHALL have parameter TIMEOUT, default 4096, max cycles allowed between extreme events.
REQ-005 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: start  in  1  run request pulse; abort  in  1  cancel run.
REQ-007 SHALL have ports: datain  in  WIDTH  signed two's-complement waveform sample; pos/neg/eq  in  1 each  slope flags from slope monitor.
REQ-008 SHALL have ports: gen_rst_n  out  1  waveform generator reset (active low); gen_en  out  1  generator enable.
REQ-009 SHALL have ports: busy  out  1; done  out  1  one-cycle pulse; timeout_err  out  1  sticky error.
REQ-010 SHALL have ports: period  out  PW; peak_max, peak_min  out  WIDTH signed; period_valid  out  1  one-cycle pulse; cycle_count  out  8.

Function
REQ-011 SHALL implement states IDLE, PRIME, ARM, MEASURE, DONE, ERR; busy=1 in PRIME, ARM, MEASURE only.
REQ-012 IDLE: gen_rst_n=0, gen_en=0; start=1 and abort=0 -> PRIME; abort wins over simultaneous start.
REQ-013 PRIME: exactly one cycle, gen_rst_n=1, gen_en=0; clears cycle_count, timeout_err, timer, direction -> ARM.
REQ-014 ARM/MEASURE: gen_rst_n=1, gen_en=1.
REQ-015 Direction register dir SHALL update to POS when pos=1, NEG when neg=1; unchanged when eq=1 or all flags 0; initialised to NONE in PRIME.
REQ-016 Max event SHALL be dir=POS and neg=1 in the same cycle; min event SHALL be dir=NEG and pos=1; both evaluated on registered dir (previous value).
REQ-017 ARM: first max event -> MEASURE; period counter loaded 1; running max/min loaded with current datain; no period_valid.
REQ-018 MEASURE: period counter increments each cycle, saturates at 2^PW-1; running max/min track signed compare of datain each cycle.
REQ-019 MEASURE max event: period <= counter value, peak_max/peak_min <= running max/min (including current sample), period_valid=1 next cycle, cycle_count increments, counter reloaded 1, running max/min reloaded with datain.
REQ-020 When cycle_count reaches NCYC on a max event -> DONE; DONE lasts one cycle, done=1, gen_en=0, gen_rst_n=1, then IDLE.
REQ-021 Timeout timer SHALL clear on PRIME and every max or min event, increment in ARM/MEASURE; on reaching TIMEOUT -> ERR.
REQ-022 ERR: gen_en=0, gen_rst_n=0, timeout_err=1 held; start -> PRIME (clears error); abort -> IDLE with timeout_err cleared.
REQ-023 abort=1 in PRIME/ARM/MEASURE -> IDLE next cycle, no done, period/peaks retain last values.
REQ-024 start while busy SHALL be ignored.
REQ-025 period, peak_max, peak_min, cycle_count SHALL hold value until next update or reset.

Reset
REQ-026 reset=0 SHALL immediately force IDLE, gen_rst_n=0, gen_en=0, busy=0, done=0, period_valid=0, timeout_err=0, period=0, peak_max=0, peak_min=0, cycle_count=0, dir=NONE.
REQ-027 Reset asserted mid-run SHALL abandon the run with no done or period_valid pulse; release returns to IDLE awaiting start.

Verification
REQ-028 Basic run: NCYC=4, start pulse, flags pos 50 cycles / neg 50 cycles repeating, datain +1000 at pos end, -1000 at neg end -> four period_valid pulses, period=100, peak_max=1000, peak_min=-1000, cycle_count 1..4, one done pulse, gen_en low after DONE.
REQ-029 Sequencing: start in IDLE -> gen_rst_n rises cycle 1, gen_en rises cycle 2, busy high from cycle 1.
REQ-030 eq plateau: pos 40, eq 10, neg 50 repeating -> eq ignored for direction, period=100 reported.
REQ-031 Timeout: TIMEOUT=64, flags held pos constantly -> ERR after 64 cycles, timeout_err=1, gen_en=0; start -> PRIME, timeout_err=0.
REQ-032 Abort/start contention: abort mid-MEASURE after 2 periods -> IDLE next cycle, no done, cycle_count=2; start+abort same cycle in IDLE -> stays IDLE.
REQ-033 Async reset mid-MEASURE (asserted between clock edges) -> outputs zero before next edge; no pulses on release.

Source files
------------

// File: rtl/slope_sequencer.sv
// Slope-driven measurement sequencer: primes a waveform generator, then times NCYC
// periods between successive waveform maxima and reports period and per-period peaks.
module slope_sequencer #(
  parameter int WIDTH   = 16,
  parameter int PW      = 16,
  parameter int NCYC    = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic signed [WIDTH-1:0] datain,
  input  logic                    pos,
  input  logic                    neg,
  input  logic                    eq,
  output logic                    gen_rst_n,
  output logic                    gen_en,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout_err,
  output logic [PW-1:0]           period,
  output logic signed [WIDTH-1:0] peak_max,
  output logic signed [WIDTH-1:0] peak_min,
  output logic                    period_valid,
  output logic [7:0]              cycle_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRIME = 3'd1;
  localparam logic [2:0] S_ARM   = 3'd2;
  localparam logic [2:0] S_MEAS  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_POS  = 2'd1;
  localparam logic [1:0] DIR_NEG  = 2'd2;

  localparam logic [PW-1:0] TMO_LAST = PW'(TIMEOUT - 1);
  localparam logic [7:0]    NCYC_L   = 8'(NCYC);

  function automatic logic [PW-1:0] sat_inc(input logic [PW-1:0] v);
    return (v == {PW{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic signed [WIDTH-1:0] smax(input logic signed [WIDTH-1:0] a,
                                                    input logic signed [WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [WIDTH-1:0] smin(input logic signed [WIDTH-1:0] a,
                                                    input logic signed [WIDTH-1:0] b);
    return (a < b) ? a : b;
  endfunction

  logic [2:0]              state_q, state_d;
  logic [1:0]              dir_q, dir_d;
  logic [PW-1:0]           timer_q, timer_d;
  logic [7:0]              cyc_q, cyc_d;
  logic [PW-1:0]           period_q, period_d;
  logic signed [WIDTH-1:0] pmax_q, pmax_d;
  logic signed [WIDTH-1:0] pmin_q, pmin_d;
  logic                    pv_q, pv_d;
  logic                    err_q, err_d;

  logic [PW-1:0]           cnt_q;
  logic signed [WIDTH-1:0] rmax_q, rmin_q;

  logic max_ev, min_ev, active, load_run, track_run;

  // Extremes are detected against the direction seen before this cycle's flags.
  assign max_ev    = (dir_q == DIR_POS) && neg;
  assign min_ev    = (dir_q == DIR_NEG) && pos;
  assign active    = (state_q == S_ARM) || (state_q == S_MEAS);
  assign load_run  = active && max_ev && !abort;
  assign track_run = (state_q == S_MEAS) && !max_ev;

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    timer_d  = timer_q;
    cyc_d    = cyc_q;
    period_d = period_q;
    pmax_d   = pmax_q;
    pmin_d   = pmin_q;
    pv_d     = 1'b0;
    err_d    = err_q;

    if (active) begin
      if (!eq && pos)      dir_d = DIR_POS;
      else if (!eq && neg) dir_d = DIR_NEG;
    end

    case (state_q)
      S_IDLE: begin
        if (start && !abort) state_d = S_PRIME;
      end
      S_PRIME: begin
        dir_d   = DIR_NONE;
        timer_d = '0;
        cyc_d   = '0;
        err_d   = 1'b0;
        state_d = abort ? S_IDLE : S_ARM;
      end
      S_ARM, S_MEAS: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (max_ev) begin
          timer_d = '0;
          if (state_q == S_ARM) begin
            state_d = S_MEAS;
          end else begin
            period_d = cnt_q;
            pmax_d   = smax(rmax_q, datain);
            pmin_d   = smin(rmin_q, datain);
            pv_d     = 1'b1;
            cyc_d    = cyc_q + 8'd1;
            if (cyc_q + 8'd1 == NCYC_L) state_d = S_DONE;
          end
        end else if (min_ev) begin
          timer_d = '0;
        end else if (timer_q == TMO_LAST) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERR: begin
        if (abort) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
        end else if (start) begin
          state_d = S_PRIME;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      dir_q    <= DIR_NONE;
      timer_q  <= '0;
      cyc_q    <= '0;
      period_q <= '0;
      pmax_q   <= '0;
      pmin_q   <= '0;
      pv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      timer_q  <= timer_d;
      cyc_q    <= cyc_d;
      period_q <= period_d;
      pmax_q   <= pmax_d;
      pmin_q   <= pmin_d;
      pv_q     <= pv_d;
      err_q    <= err_d;
    end
  end

  // Running period counter and extremes; only meaningful while measuring.
  always_ff @(posedge clk) begin
    if (load_run) begin
      cnt_q  <= PW'(1);
      rmax_q <= datain;
      rmin_q <= datain;
    end else if (track_run) begin
      cnt_q  <= sat_inc(cnt_q);
      rmax_q <= smax(rmax_q, datain);
      rmin_q <= smin(rmin_q, datain);
    end
  end

  assign gen_rst_n    = (state_q == S_PRIME) || (state_q == S_ARM) ||
                        (state_q == S_MEAS)  || (state_q == S_DONE);
  assign gen_en       = active;
  assign busy         = (state_q == S_PRIME) || active;
  assign done         = (state_q == S_DONE);
  assign timeout_err  = err_q;
  assign period       = period_q;
  assign peak_max     = pmax_q;
  assign peak_min     = pmin_q;
  assign period_valid = pv_q;
  assign cycle_count  = cyc_q;

endmodule

// File: tb/tb_slope_sequencer.sv
// Directed bench for slope_sequencer: control-sequence vector table plus
// hand-written multi-cycle runs (measurement, eq plateau, abort, async reset, timeout).
module tb_slope_sequencer;

  logic              clk = 1'b0;
  logic              reset, start, abort, pos, neg, eq;
  logic signed [15:0] datain;
  logic              gen_rst_n, gen_en, busy, done, timeout_err, period_valid;
  logic [15:0]       period;
  logic signed [15:0] peak_max, peak_min;
  logic [7:0]        cycle_count;

  int checks = 0;
  int failures = 0;

  slope_sequencer #(.WIDTH(16), .PW(16), .NCYC(4), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .datain(datain), .pos(pos), .neg(neg), .eq(eq),
    .gen_rst_n(gen_rst_n), .gen_en(gen_en), .busy(busy), .done(done),
    .timeout_err(timeout_err), .period(period), .peak_max(peak_max),
    .peak_min(peak_min), .period_valid(period_valid), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit       st;
    bit       ab;
    bit       p;
    bit       n;
    bit [5:0] exp;   // {gen_rst_n, gen_en, busy, done, timeout_err, period_valid}
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_wave(input int t, input int np, input int ne, input int nn);
    int per, m;
    per = np + ne + nn;
    m = t % per;
    pos = (m < np);
    eq  = (m >= np) && (m < np + ne);
    neg = (m >= np + ne);
    if (m == np + ne - 1)  datain = 16'sd1000;
    else if (m == per - 1) datain = -16'sd1000;
    else                   datain = 16'sd0;
  endtask

  // mode 0: full run to done; 1: abort after two periods; 2: async reset after one period
  task automatic run_seq(input int np, input int ne, input int nn, input int mode, input string tag);
    int npv, ndone, per, bad;
    bit reached;
    npv = 0; ndone = 0; reached = 0; bad = 0;
    per = np + ne + nn;
    start = 1'b1; set_wave(0, np, ne, nn); tick; start = 1'b0;
    chk({tag, "_cyc1"}, {gen_rst_n, gen_en, busy}, 3'b101);
    set_wave(1, np, ne, nn); tick;
    chk({tag, "_cyc2"}, {gen_rst_n, gen_en, busy}, 3'b111);
    for (int t = 2; t < 700; t++) begin
      set_wave(t, np, ne, nn); tick;
      if (period_valid) begin
        npv++;
        chk({tag, "_period"}, period, per);
        chk({tag, "_peak_max"}, peak_max, 1000);
        chk({tag, "_peak_min"}, peak_min, -1000);
        chk({tag, "_cycle_count"}, cycle_count, npv);
      end
      if (done) ndone++;
      if (mode == 0 && ndone == 1) begin
        reached = 1;
        chk({tag, "_pv_with_done"}, period_valid, 1);
        set_wave(t + 1, np, ne, nn); tick;
        chk({tag, "_after_done"}, {gen_rst_n, gen_en, busy, done}, 4'b0000);
        break;
      end
      if (mode == 1 && npv == 2 && period_valid) begin
        reached = 1;
        for (int k = 1; k <= 10; k++) begin set_wave(t + k, np, ne, nn); tick; end
        abort = 1'b1; set_wave(t + 11, np, ne, nn); tick; abort = 1'b0;
        chk({tag, "_abort_state"}, {gen_rst_n, gen_en, busy, done}, 4'b0000);
        chk({tag, "_abort_cyc"}, cycle_count, 2);
        chk({tag, "_abort_period"}, period, per);
        chk({tag, "_abort_pmax"}, peak_max, 1000);
        for (int k = 12; k < 40; k++) begin
          set_wave(t + k, np, ne, nn); tick;
          if (done || period_valid || busy) bad++;
        end
        chk({tag, "_abort_quiet"}, bad, 0);
        break;
      end
      if (mode == 2 && npv == 1 && period_valid) begin
        reached = 1;
        for (int k = 1; k <= 5; k++) begin set_wave(t + k, np, ne, nn); tick; end
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        chk({tag, "_rst_ctrl"}, {gen_rst_n, gen_en, busy, done, timeout_err, period_valid}, 0);
        chk({tag, "_rst_period"}, period, 0);
        chk({tag, "_rst_peaks"}, {peak_max, peak_min}, 0);
        chk({tag, "_rst_cyc"}, cycle_count, 0);
        tick; tick;
        reset = 1'b1;
        for (int k = 6; k < 40; k++) begin
          set_wave(t + k, np, ne, nn); tick;
          if (done || period_valid || busy || gen_en) bad++;
        end
        chk({tag, "_rst_quiet"}, bad, 0);
        break;
      end
    end
    chk({tag, "_reached"}, reached, 1);
    if (mode == 0) begin
      chk({tag, "_npv"}, npv, 4);
      chk({tag, "_ndone"}, ndone, 1);
    end
  endtask

  initial begin
    tbl[0]  = '{1, 1, 0, 0, 6'b000000};
    tbl[1]  = '{0, 0, 0, 0, 6'b000000};
    tbl[2]  = '{1, 0, 0, 0, 6'b101000};
    tbl[3]  = '{1, 0, 0, 0, 6'b111000};
    tbl[4]  = '{1, 0, 0, 0, 6'b111000};
    tbl[5]  = '{0, 1, 0, 0, 6'b000000};
    tbl[6]  = '{0, 0, 0, 0, 6'b000000};
    tbl[7]  = '{1, 0, 0, 0, 6'b101000};
    tbl[8]  = '{0, 1, 0, 0, 6'b000000};
    tbl[9]  = '{1, 0, 0, 0, 6'b101000};
    tbl[10] = '{0, 0, 1, 0, 6'b111000};
    tbl[11] = '{0, 0, 1, 0, 6'b111000};
    tbl[12] = '{0, 0, 0, 1, 6'b111000};
    tbl[13] = '{0, 0, 0, 1, 6'b111000};
    tbl[14] = '{0, 1, 0, 0, 6'b000000};
    tbl[15] = '{0, 0, 0, 0, 6'b000000};

    reset = 1'b0; start = 1'b0; abort = 1'b0;
    pos = 1'b0; neg = 1'b0; eq = 1'b0; datain = 16'sd0;
    tick; tick;
    chk("reset_ctrl", {gen_rst_n, gen_en, busy, done, timeout_err, period_valid}, 0);
    chk("reset_period", period, 0);
    chk("reset_peaks", {peak_max, peak_min}, 0);
    chk("reset_cyc", cycle_count, 0);
    reset = 1'b1;
    tick;

    for (int i = 0; i < 16; i++) begin
      start = tbl[i].st; abort = tbl[i].ab; pos = tbl[i].p; neg = tbl[i].n;
      eq = 1'b0; datain = 16'sd0;
      tick;
      chk($sformatf("vec%0d", i),
          {gen_rst_n, gen_en, busy, done, timeout_err, period_valid}, tbl[i].exp);
    end
    start = 1'b0; abort = 1'b0; pos = 1'b0; neg = 1'b0;
    tick;

    run_seq(50, 0, 50, 0, "basic");
    run_seq(40, 10, 50, 0, "eqplat");
    run_seq(50, 0, 50, 1, "abort");
    run_seq(50, 0, 50, 2, "areset");

    pos = 1'b1; neg = 1'b0; eq = 1'b0; datain = 16'sd5;
    start = 1'b1; tick; start = 1'b0;
    repeat (64) tick;
    chk("to_before", {timeout_err, gen_en, busy}, 3'b011);
    tick;
    chk("to_err", {timeout_err, gen_en, gen_rst_n, busy}, 4'b1000);
    repeat (3) tick;
    chk("to_hold", {timeout_err, gen_en}, 2'b10);
    start = 1'b1; tick; start = 1'b0;
    chk("to_restart", {timeout_err, gen_rst_n, gen_en, busy}, 4'b0101);
    chk("to_restart_cyc", cycle_count, 0);
    repeat (65) tick;
    chk("to_err2", timeout_err, 1);
    abort = 1'b1; tick; abort = 1'b0;
    chk("to_abort", {timeout_err, busy, gen_rst_n, gen_en}, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
